// File: rtl/corevx_bus_arbiter.sv
// 2:1 round-robin arbiter merging the instruction (i_*) and data (d_*) masters onto one
// memory port (m_*). The grant is held for a whole burst, and a per-grant watchdog aborts stalled accesses.
module corevx_bus_arbiter #(
    parameter int ADDR_W  = 34,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_transaction,
    input  logic [2:0]            i_cmd,
    input  logic [ADDR_W-1:0]     i_address,
    input  logic [3:0]            i_burstcount,
    input  logic [DATA_W-1:0]     i_wdata,
    input  logic [DATA_W/8-1:0]   i_wbyte_enable,
    output logic                  i_transaction_done,
    output logic [2:0]            i_transaction_response,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_transaction,
    input  logic [2:0]            d_cmd,
    input  logic [ADDR_W-1:0]     d_address,
    input  logic [3:0]            d_burstcount,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wbyte_enable,
    output logic                  d_transaction_done,
    output logic [2:0]            d_transaction_response,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_transaction,
    output logic [2:0]            m_cmd,
    output logic [ADDR_W-1:0]     m_address,
    output logic [3:0]            m_burstcount,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wbyte_enable,
    input  logic                  m_transaction_done,
    input  logic [2:0]            m_transaction_response,
    input  logic [DATA_W-1:0]     m_rdata,
    output logic                  grant_i,
    output logic                  grant_d,
    output logic                  timeout_event,
    output logic [1:0]            o_dbg_state
);

    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last_d;
    logic [3:0]          r_beat_cnt;
    logic [WDOG_W-1:0]   r_wdog;

    logic                w_in_grant;
    logic                w_own_d;
    logic                w_own_txn;
    logic [3:0]          w_own_bc;
    logic [3:0]          w_bc_eff;
    logic                w_done;
    logic                w_last_beat;
    logic                w_timeout;
    logic                w_abandon;

    // Handshake: a master holds x_transaction (and its request fields) until the
    // done pulse of its final beat; each m_transaction_done completes exactly one beat.
    function automatic state_t f_arb(input logic req_i, input logic req_d, input logic last_d);
        if (req_i && req_d) begin
            return last_d ? ST_GRANT_I : ST_GRANT_D;
        end else if (req_d) begin
            return ST_GRANT_D;
        end else if (req_i) begin
            return ST_GRANT_I;
        end
        return ST_IDLE;
    endfunction

    assign w_in_grant  = (r_state != ST_IDLE);
    assign w_own_d     = (r_state == ST_GRANT_D);
    assign w_own_txn   = w_own_d ? d_transaction : i_transaction;
    assign w_own_bc    = w_own_d ? d_burstcount : i_burstcount;
    assign w_bc_eff    = (w_own_bc == 4'd0) ? 4'd1 : w_own_bc;
    assign w_done      = w_in_grant && m_transaction_done;
    assign w_last_beat = w_done && ((({1'b0, r_beat_cnt} + 5'd1) == {1'b0, w_bc_eff}) ||
                                    (m_transaction_response != 3'd0));
    // A pending done always beats an expiring watchdog.
    assign w_timeout   = (TIMEOUT != 0) && w_in_grant && !m_transaction_done && (r_wdog == WDOG_MAX);
    // A re-grant whose request was withdrawn before any beat simply releases the port.
    assign w_abandon   = w_in_grant && !w_done && !w_timeout && !w_own_txn && (r_beat_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_last_d   <= 1'b0;
            r_beat_cnt <= 4'd0;
            r_wdog     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_last_beat || w_timeout) begin
                r_last_d <= w_own_d;
            end
            if (w_done) begin
                r_beat_cnt <= w_last_beat ? 4'd0 : r_beat_cnt + 4'd1;
            end else if (w_next_state != r_state) begin
                r_beat_cnt <= 4'd0;
            end
            if (w_in_grant && !w_done && (w_next_state == r_state)) begin
                r_wdog <= r_wdog + 1'b1;
            end else begin
                r_wdog <= '0;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: w_next_state = f_arb(i_transaction, d_transaction, r_last_d);
            ST_GRANT_I,
            ST_GRANT_D: begin
                if (w_last_beat) begin
                    w_next_state = f_arb(i_transaction, d_transaction, w_own_d);
                end else if (w_timeout || w_abandon) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        m_transaction          = 1'b0;
        m_cmd                  = 3'd0;
        m_address              = '0;
        m_burstcount           = 4'd0;
        m_wdata                = '0;
        m_wbyte_enable         = '0;
        i_transaction_done     = 1'b0;
        i_transaction_response = 3'd0;
        i_rdata                = '0;
        d_transaction_done     = 1'b0;
        d_transaction_response = 3'd0;
        d_rdata                = '0;
        grant_i                = 1'b0;
        grant_d                = 1'b0;
        timeout_event          = w_timeout && !rst;
        o_dbg_state            = r_state;
        case (r_state)
            ST_GRANT_I: begin
                grant_i                = 1'b1;
                m_transaction          = i_transaction && !w_timeout;
                m_cmd                  = i_cmd;
                m_address              = i_address;
                m_burstcount           = i_burstcount;
                m_wdata                = i_wdata;
                m_wbyte_enable         = i_wbyte_enable;
                i_transaction_done     = (m_transaction_done || w_timeout) && !rst;
                i_transaction_response = w_timeout ? 3'b111 : m_transaction_response;
                i_rdata                = m_rdata;
            end
            ST_GRANT_D: begin
                grant_d                = 1'b1;
                m_transaction          = d_transaction && !w_timeout;
                m_cmd                  = d_cmd;
                m_address              = d_address;
                m_burstcount           = d_burstcount;
                m_wdata                = d_wdata;
                m_wbyte_enable         = d_wbyte_enable;
                d_transaction_done     = (m_transaction_done || w_timeout) && !rst;
                d_transaction_response = w_timeout ? 3'b111 : m_transaction_response;
                d_rdata                = m_rdata;
            end
            default: ;
        endcase
    end

    // Dropping the request after a beat has completed is a master protocol violation.
    a_no_drop_i: assert property (@(posedge clk) disable iff (rst)
        (r_state == ST_GRANT_I && r_beat_cnt != 4'd0) |-> i_transaction);
    a_no_drop_d: assert property (@(posedge clk) disable iff (rst)
        (r_state == ST_GRANT_D && r_beat_cnt != 4'd0) |-> d_transaction);

endmodule

// File: tb/tb_corevx_bus_arbiter.sv
// Cycle-by-cycle vector bench for corevx_bus_arbiter with a short watchdog (TIMEOUT=8).
module tb_corevx_bus_arbiter;

    localparam int ADDR_W = 34;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] I_ADDR = 34'h2_0000_0100;
    localparam logic [ADDR_W-1:0] D_ADDR = 34'h1_0000_0200;
    localparam logic [2:0] I_CMD = 3'd1;
    localparam logic [2:0] D_CMD = 3'd2;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_transaction, d_transaction;
    logic [2:0]          i_cmd, d_cmd;
    logic [ADDR_W-1:0]   i_address, d_address;
    logic [3:0]          i_burstcount, d_burstcount;
    logic [DATA_W-1:0]   i_wdata, d_wdata;
    logic [DATA_W/8-1:0] i_wbyte_enable, d_wbyte_enable;
    logic                i_transaction_done, d_transaction_done;
    logic [2:0]          i_transaction_response, d_transaction_response;
    logic [DATA_W-1:0]   i_rdata, d_rdata;
    logic                m_transaction;
    logic [2:0]          m_cmd;
    logic [ADDR_W-1:0]   m_address;
    logic [3:0]          m_burstcount;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wbyte_enable;
    logic                m_transaction_done;
    logic [2:0]          m_transaction_response;
    logic [DATA_W-1:0]   m_rdata;
    logic                grant_i, grant_d, timeout_event;
    logic [1:0]          o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       rst;
        logic       it;
        logic [3:0] ibc;
        logic       dt;
        logic [3:0] dbc;
        logic       md;
        logic [2:0] mr;
        logic       gi;
        logic       gd;
        logic       mt;
        logic       idn;
        logic       ddn;
        logic [2:0] ir;
        logic [2:0] dr;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    corevx_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_transaction(i_transaction), .i_cmd(i_cmd), .i_address(i_address),
        .i_burstcount(i_burstcount), .i_wdata(i_wdata), .i_wbyte_enable(i_wbyte_enable),
        .i_transaction_done(i_transaction_done), .i_transaction_response(i_transaction_response),
        .i_rdata(i_rdata),
        .d_transaction(d_transaction), .d_cmd(d_cmd), .d_address(d_address),
        .d_burstcount(d_burstcount), .d_wdata(d_wdata), .d_wbyte_enable(d_wbyte_enable),
        .d_transaction_done(d_transaction_done), .d_transaction_response(d_transaction_response),
        .d_rdata(d_rdata),
        .m_transaction(m_transaction), .m_cmd(m_cmd), .m_address(m_address),
        .m_burstcount(m_burstcount), .m_wdata(m_wdata), .m_wbyte_enable(m_wbyte_enable),
        .m_transaction_done(m_transaction_done), .m_transaction_response(m_transaction_response),
        .m_rdata(m_rdata),
        .grant_i(grant_i), .grant_d(grant_d), .timeout_event(timeout_event),
        .o_dbg_state(o_dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    task automatic v(input logic rst_i, input logic it, input logic [3:0] ibc,
                     input logic dt, input logic [3:0] dbc, input logic md, input logic [2:0] mr,
                     input logic gi, input logic gd, input logic mt, input logic idn,
                     input logic ddn, input logic [2:0] ir, input logic [2:0] dr, input logic to);
        vec_t e;
        e.rst = rst_i; e.it = it; e.ibc = ibc; e.dt = dt; e.dbc = dbc; e.md = md; e.mr = mr;
        e.gi = gi; e.gd = gd; e.mt = mt; e.idn = idn; e.ddn = ddn; e.ir = ir; e.dr = dr; e.to = to;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t e, input int idx);
        rst                    = e.rst;
        i_transaction          = e.it;
        i_burstcount           = e.ibc;
        d_transaction          = e.dt;
        d_burstcount           = e.dbc;
        m_transaction_done     = e.md;
        m_transaction_response = e.mr;
        m_rdata                = 32'hC0DE_0000 + DATA_W'(idx);
    endtask

    task automatic compare(input vec_t e, input int idx);
        logic [ADDR_W-1:0] exp_addr;
        logic [2:0]        exp_cmd;
        exp_addr = e.gi ? I_ADDR : (e.gd ? D_ADDR : '0);
        exp_cmd  = e.gi ? I_CMD : (e.gd ? D_CMD : 3'd0);
        chk("grant_i",       idx, 64'(grant_i), 64'(e.gi));
        chk("grant_d",       idx, 64'(grant_d), 64'(e.gd));
        chk("dbg_state",     idx, 64'(o_dbg_state), 64'({e.gd, e.gi}));
        chk("m_transaction", idx, 64'(m_transaction), 64'(e.mt));
        chk("m_address",     idx, 64'(m_address), 64'(exp_addr));
        chk("m_cmd",         idx, 64'(m_cmd), 64'(exp_cmd));
        chk("i_done",        idx, 64'(i_transaction_done), 64'(e.idn));
        chk("d_done",        idx, 64'(d_transaction_done), 64'(e.ddn));
        chk("i_resp",        idx, 64'(i_transaction_response), 64'(e.ir));
        chk("d_resp",        idx, 64'(d_transaction_response), 64'(e.dr));
        chk("timeout_event", idx, 64'(timeout_event), 64'(e.to));
        chk("i_rdata",       idx, 64'(i_rdata), e.gi ? 64'(m_rdata) : 64'd0);
        chk("d_rdata",       idx, 64'(d_rdata), e.gd ? 64'(m_rdata) : 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        i_transaction = 1'b0; d_transaction = 1'b0;
        i_cmd = I_CMD; d_cmd = D_CMD;
        i_address = I_ADDR; d_address = D_ADDR;
        i_burstcount = 4'd0; d_burstcount = 4'd0;
        i_wdata = 32'h1111_1111; d_wdata = 32'h2222_2222;
        i_wbyte_enable = 4'hF; d_wbyte_enable = 4'h3;
        m_transaction_done = 1'b0; m_transaction_response = 3'd0; m_rdata = '0;

        //  rst it ibc dt dbc md mr   gi gd mt idn ddn ir dr to
        // Reset state, then simultaneous I/D request: D wins the first tie, 4-beat burst.
        v(0, 0,0, 0,0, 0,0,  0,0,0,0,0,0,0,0);
        v(0, 1,1, 1,4, 0,0,  0,0,0,0,0,0,0,0);
        for (int k = 0; k < 4; k++) v(0, 1,1, 1,4, 1,0,  0,1,1,0,1,0,0,0);
        // Grant passes to the waiting I without an IDLE bubble.
        v(0, 1,1, 0,0, 0,0,  1,0,1,0,0,0,0,0);
        v(0, 1,1, 0,0, 1,0,  1,0,1,1,0,0,0,0);
        v(0, 0,0, 0,0, 0,0,  1,0,0,0,0,0,0,0);
        v(0, 0,0, 0,0, 0,0,  0,0,0,0,0,0,0,0);
        // I alone with burstcount 0: single beat.
        v(0, 1,0, 0,0, 0,0,  0,0,0,0,0,0,0,0);
        v(0, 1,0, 0,0, 1,0,  1,0,1,1,0,0,0,0);
        v(0, 0,0, 0,0, 0,0,  1,0,0,0,0,0,0,0);
        v(0, 0,0, 0,0, 0,0,  0,0,0,0,0,0,0,0);
        // D burst of 4 terminated by an error response on beat 2.
        v(0, 0,0, 1,4, 0,0,  0,0,0,0,0,0,0,0);
        v(0, 0,0, 1,4, 1,0,  0,1,1,0,1,0,0,0);
        v(0, 0,0, 1,4, 1,2,  0,1,1,0,1,0,2,0);
        v(0, 0,0, 0,0, 0,0,  0,1,0,0,0,0,0,0);
        v(0, 0,0, 0,0, 0,0,  0,0,0,0,0,0,0,0);
        // Tie with D as last owner: I first, then D.
        v(0, 1,1, 1,1, 0,0,  0,0,0,0,0,0,0,0);
        v(0, 1,1, 1,1, 1,0,  1,0,1,1,0,0,0,0);
        v(0, 0,0, 1,1, 1,0,  0,1,1,0,1,0,0,0);
        v(0, 0,0, 0,0, 0,0,  0,1,0,0,0,0,0,0);
        v(0, 0,0, 0,0, 0,0,  0,0,0,0,0,0,0,0);
        // Memory never responds: watchdog fires at wdog==8, late done ignored.
        v(0, 0,0, 1,1, 0,0,  0,0,0,0,0,0,0,0);
        for (int k = 0; k < 8; k++) v(0, 0,0, 1,1, 0,0,  0,1,1,0,0,0,0,0);
        v(0, 0,0, 1,1, 0,0,  0,1,0,0,1,0,7,1);
        v(0, 0,0, 0,0, 1,0,  0,0,0,0,0,0,0,0);
        // Done arriving exactly at watchdog expiry wins.
        v(0, 0,0, 1,2, 0,0,  0,0,0,0,0,0,0,0);
        for (int k = 0; k < 8; k++) v(0, 0,0, 1,2, 0,0,  0,1,1,0,0,0,0,0);
        v(0, 0,0, 1,2, 1,0,  0,1,1,0,1,0,0,0);
        v(0, 0,0, 1,2, 1,0,  0,1,1,0,1,0,0,0);
        v(0, 0,0, 0,0, 0,0,  0,1,0,0,0,0,0,0);
        v(0, 0,0, 0,0, 0,0,  0,0,0,0,0,0,0,0);
        // Reset on beat 2 of an I burst: no done, IDLE next cycle.
        v(0, 1,4, 0,0, 0,0,  0,0,0,0,0,0,0,0);
        v(0, 1,4, 0,0, 1,0,  1,0,1,1,0,0,0,0);
        v(1, 1,4, 0,0, 1,0,  1,0,1,0,0,0,0,0);
        v(0, 0,0, 0,0, 1,0,  0,0,0,0,0,0,0,0);
        v(0, 0,0, 0,0, 0,0,  0,0,0,0,0,0,0,0);

        repeat (2) @(posedge clk);
        for (int k = 0; k < tbl.size(); k++) begin
            @(posedge clk);
            #1;
            drive(tbl[k], k);
            #3;
            compare(tbl[k], k);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
